// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arbState_e;

    localparam int DATA_BITS_DEFAULT = 8;

    // Round-robin pointer advance: idx+1 wrapped into 0..n-1.
    function automatic int nextIndex(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after Ptr, wrapping.
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         ReqValid,
    input  logic [$clog2(NUM_REQ)-1:0] Ptr,
    output logic [NUM_REQ-1:0]         Grant,
    output logic [$clog2(NUM_REQ)-1:0] GrantIdx,
    output logic                       AnyValid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic found;
    int   cand;

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        Grant    = '0;
        GrantIdx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(Ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && ReqValid[cand]) begin
                found       = 1'b1;
                Grant[cand] = 1'b1;
                GrantIdx    = IDX_W'(cand);
            end
        end
    end

    assign AnyValid = |ReqValid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, with done watchdog and
// a Tick-counted inter-frame gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = DATA_BITS_DEFAULT,
    parameter int GAP_TICKS      = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                           Clock,
    input  logic                           ResetN,
    input  logic                           Tick,
    input  logic [NUM_REQ-1:0]             ReqValid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   ReqData,
    output logic [NUM_REQ-1:0]             ReqReady,
    output logic                           TxStart,
    output logic [DATA_BITS-1:0]           TxData,
    input  logic                           TxDone,
    output logic                           Busy,
    output logic [$clog2(NUM_REQ)-1:0]     GrantId,
    output logic                           TimeoutErr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    // Watchdog fires on the cycle whose increment would reach TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam arbState_e        POST_FRAME = (GAP_TICKS == 0) ? IDLE : GAP;

    arbState_e state;
    arbState_e nextState;

    logic [IDX_W-1:0]   ptr;
    logic [TO_W-1:0]    wdCnt;
    logic [GAP_W-1:0]   gapCnt;

    logic [NUM_REQ-1:0] pickGrant;
    logic [IDX_W-1:0]   pickIdx;
    logic               anyValid;
    logic               acceptNow;
    logic               wdExpire;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) uRrPick (
        .ReqValid (ReqValid),
        .Ptr      (ptr),
        .Grant    (pickGrant),
        .GrantIdx (pickIdx),
        .AnyValid (anyValid)
    );

    // NOTE: reset is sampled on the clock edge only; ResetN is never in the sensitivity list.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ReqReady  = '0;
        acceptNow = 1'b0;
        wdExpire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (anyValid) begin
                    ReqReady  = pickGrant;
                    acceptNow = 1'b1;
                    nextState = START;
                end
            end
            START: begin
                nextState = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done strobe in the expiry cycle takes precedence over the abort.
                if (TxDone) begin
                    nextState = POST_FRAME;
                end else if (wdCnt == TO_LAST) begin
                    wdExpire  = 1'b1;
                    nextState = POST_FRAME;
                end
            end
            GAP: begin
                if (Tick && (gapCnt == GAP_LAST)) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            TxStart    <= 1'b0;
            TxData     <= '0;
            GrantId    <= '0;
            TimeoutErr <= 1'b0;
            ptr        <= '0;
            wdCnt      <= '0;
            gapCnt     <= '0;
        end else begin
            TxStart    <= acceptNow;
            TimeoutErr <= wdExpire;

            if (acceptNow) begin
                TxData  <= ReqData[int'(pickIdx)*DATA_BITS +: DATA_BITS];
                GrantId <= pickIdx;
                ptr     <= IDX_W'(nextIndex(int'(pickIdx), NUM_REQ));
            end

            // The last increment lands exactly on TIMEOUT_CYCLES-1 and the state exits, so no wrap.
            if (state == START) begin
                wdCnt <= '0;
            end else if ((state == WAIT_DONE) && !TxDone) begin
                wdCnt <= wdCnt + 1'b1;
            end

            if (state != GAP) begin
                gapCnt <= '0;
            end else if (Tick) begin
                gapCnt <= gapCnt + 1'b1;
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut A (gap 16, timeout 20) and dut B (gap 0).
module tb_uart_tx_arbiter;

    logic        Clock;
    logic        ResetN;
    logic        Tick;
    logic [3:0]  ReqValid;
    logic [31:0] ReqData;
    logic        TxDone;

    logic [3:0]  aReqReady, bReqReady;
    logic        aTxStart, bTxStart;
    logic [7:0]  aTxData, bTxData;
    logic        aBusy, bBusy;
    logic [1:0]  aGrantId, bGrantId;
    logic        aTimeoutErr, bTimeoutErr;

    int vecs = 0;
    int errs = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .GAP_TICKS(16), .TIMEOUT_CYCLES(20)
    ) dutA (
        .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .ReqValid(ReqValid),
        .ReqData(ReqData), .ReqReady(aReqReady), .TxStart(aTxStart),
        .TxData(aTxData), .TxDone(TxDone), .Busy(aBusy), .GrantId(aGrantId),
        .TimeoutErr(aTimeoutErr)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_BITS(8), .GAP_TICKS(0), .TIMEOUT_CYCLES(20)
    ) dutB (
        .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .ReqValid(ReqValid),
        .ReqData(ReqData), .ReqReady(bReqReady), .TxStart(bTxStart),
        .TxData(bTxData), .TxDone(TxDone), .Busy(bBusy), .GrantId(bGrantId),
        .TimeoutErr(bTimeoutErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change 2 time units after each rising edge; outputs are read 1 unit later.
    task automatic nextCycle();
        @(posedge Clock);
        #2;
    endtask

    task automatic doReset();
        ResetN   = 1'b0;
        Tick     = 1'b0;
        TxDone   = 1'b0;
        ReqValid = 4'b0000;
        nextCycle();
        ResetN = 1'b1;
    endtask

    task automatic drainGap(input int ticks);
        for (int i = 0; i < ticks; i++) begin
            Tick = 1'b1;
            nextCycle();
        end
        Tick = 1'b0;
    endtask

    task automatic test_reset();
        ResetN   = 1'b0;
        Tick     = 1'b0;
        TxDone   = 1'b0;
        ReqValid = 4'b0000;
        ReqData  = 32'h0;
        nextCycle();
        nextCycle();
        #1;
        vecs++; if (aBusy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", aBusy); end
        vecs++; if (aTxStart !== 1'b0) begin errs++; $display("FAIL reset_txstart: got %b want 0", aTxStart); end
        vecs++; if (aTxData !== 8'h00) begin errs++; $display("FAIL reset_txdata: got %h want 00", aTxData); end
        vecs++; if (aGrantId !== 2'd0) begin errs++; $display("FAIL reset_grantid: got %0d want 0", aGrantId); end
        vecs++; if (aTimeoutErr !== 1'b0) begin errs++; $display("FAIL reset_timeout: got %b want 0", aTimeoutErr); end
        vecs++; if (aReqReady !== 4'b0000) begin errs++; $display("FAIL reset_ready: got %b want 0000", aReqReady); end
        ResetN = 1'b1;
        nextCycle();
    endtask

    task automatic test_single();
        doReset();
        ReqData  = 32'h0000_0055;
        ReqValid = 4'b0001;
        #1;
        vecs++; if (aReqReady !== 4'b0001) begin errs++; $display("FAIL single_ready: got %b want 0001", aReqReady); end
        nextCycle();
        ReqValid = 4'b0000;
        #1;
        vecs++; if (aTxStart !== 1'b1) begin errs++; $display("FAIL single_txstart: got %b want 1", aTxStart); end
        vecs++; if (aTxData !== 8'h55) begin errs++; $display("FAIL single_txdata: got %h want 55", aTxData); end
        vecs++; if (aGrantId !== 2'd0) begin errs++; $display("FAIL single_grantid: got %0d want 0", aGrantId); end
        vecs++; if (aReqReady !== 4'b0000) begin errs++; $display("FAIL single_ready_start: got %b want 0000", aReqReady); end
        nextCycle();
        #1;
        vecs++; if (aTxStart !== 1'b0) begin errs++; $display("FAIL single_txstart_once: got %b want 0", aTxStart); end
        repeat (9) nextCycle();
        TxDone = 1'b1;
        nextCycle();
        TxDone = 1'b0;
        #1;
        vecs++; if (aBusy !== 1'b1) begin errs++; $display("FAIL single_gap_busy: got %b want 1", aBusy); end
        vecs++; if (aTxData !== 8'h55) begin errs++; $display("FAIL single_txdata_hold: got %h want 55", aTxData); end
        for (int i = 0; i < 16; i++) begin
            Tick = 1'b1;
            nextCycle();
            Tick = 1'b0;
            if (i == 14) begin
                #1;
                vecs++; if (aBusy !== 1'b1) begin errs++; $display("FAIL single_gap_15: got busy %b want 1", aBusy); end
            end
            nextCycle();
        end
        #1;
        vecs++; if (aBusy !== 1'b0) begin errs++; $display("FAIL single_gap_end: got busy %b want 0", aBusy); end
    endtask

    task automatic test_fairness();
        logic [1:0] expIdx;
        logic [3:0] expReady;
        doReset();
        ReqData  = 32'hA3A2_A1A0;
        ReqValid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            expIdx   = 2'(i % 4);
            expReady = 4'b0001 << expIdx;
            #1;
            vecs++; if (aReqReady !== expReady) begin errs++; $display("FAIL fair_ready[%0d]: got %b want %b", i, aReqReady, expReady); end
            nextCycle();
            #1;
            vecs++; if (aTxData !== (8'hA0 + 8'(expIdx))) begin errs++; $display("FAIL fair_txdata[%0d]: got %h want %h", i, aTxData, 8'hA0 + 8'(expIdx)); end
            vecs++; if (aGrantId !== expIdx) begin errs++; $display("FAIL fair_grantid[%0d]: got %0d want %0d", i, aGrantId, expIdx); end
            vecs++; if (aTxStart !== 1'b1) begin errs++; $display("FAIL fair_txstart[%0d]: got %b want 1", i, aTxStart); end
            repeat (5) nextCycle();
            TxDone = 1'b1;
            nextCycle();
            TxDone = 1'b0;
            drainGap(16);
        end
        ReqValid = 4'b0000;
    endtask

    task automatic test_wrap();
        doReset();
        ReqData  = 32'h00C2_00C0;
        ReqValid = 4'b0100;
        #1;
        vecs++; if (aReqReady !== 4'b0100) begin errs++; $display("FAIL wrap_ready2: got %b want 0100", aReqReady); end
        nextCycle();
        ReqValid = 4'b0101;
        nextCycle();
        TxDone = 1'b1;
        nextCycle();
        TxDone = 1'b0;
        drainGap(16);
        #1;
        vecs++; if (aReqReady !== 4'b0001) begin errs++; $display("FAIL wrap_ready0: got %b want 0001", aReqReady); end
        nextCycle();
        #1;
        vecs++; if (aGrantId !== 2'd0) begin errs++; $display("FAIL wrap_grant0: got %0d want 0", aGrantId); end
        vecs++; if (aTxData !== 8'hC0) begin errs++; $display("FAIL wrap_data0: got %h want c0", aTxData); end
        nextCycle();
        TxDone = 1'b1;
        nextCycle();
        TxDone = 1'b0;
        drainGap(16);
        #1;
        vecs++; if (aReqReady !== 4'b0100) begin errs++; $display("FAIL wrap_ready_after: got %b want 0100", aReqReady); end
        nextCycle();
        #1;
        vecs++; if (aGrantId !== 2'd2) begin errs++; $display("FAIL wrap_grant2: got %0d want 2", aGrantId); end
        ReqValid = 4'b0000;
    endtask

    task automatic test_timeout();
        doReset();
        ReqData  = 32'h0000_2211;
        ReqValid = 4'b0011;
        nextCycle();
        ReqValid = 4'b0010;
        for (int k = 1; k <= 21; k++) begin
            nextCycle();
            #1;
            vecs++; if (aTimeoutErr !== (k == 20)) begin errs++; $display("FAIL timeout_pulse[C%0d]: got %b want %b", k, aTimeoutErr, (k == 20)); end
            if (k == 20) begin
                vecs++; if (aBusy !== 1'b1) begin errs++; $display("FAIL timeout_gap_busy: got %b want 1", aBusy); end
            end
        end
        drainGap(16);
        #1;
        vecs++; if (aReqReady !== 4'b0010) begin errs++; $display("FAIL timeout_next_ready: got %b want 0010", aReqReady); end
        nextCycle();
        ReqValid = 4'b0000;
        #1;
        vecs++; if (aTxData !== 8'h22) begin errs++; $display("FAIL timeout_next_data: got %h want 22", aTxData); end
        vecs++; if (aGrantId !== 2'd1) begin errs++; $display("FAIL timeout_next_grant: got %0d want 1", aGrantId); end
        // Tie: TxDone arrives in the very cycle the watchdog would expire.
        repeat (19) nextCycle();
        #1;
        vecs++; if (aTimeoutErr !== 1'b0) begin errs++; $display("FAIL tie_pre: got %b want 0", aTimeoutErr); end
        TxDone = 1'b1;
        nextCycle();
        TxDone = 1'b0;
        #1;
        vecs++; if (aTimeoutErr !== 1'b0) begin errs++; $display("FAIL tie_no_error: got %b want 0", aTimeoutErr); end
        vecs++; if (aBusy !== 1'b1) begin errs++; $display("FAIL tie_gap_busy: got %b want 1", aBusy); end
        nextCycle();
        #1;
        vecs++; if (aTimeoutErr !== 1'b0) begin errs++; $display("FAIL tie_no_late_error: got %b want 0", aTimeoutErr); end
    endtask

    task automatic test_gap0();
        doReset();
        ReqData = 32'h0000_665A;
        TxDone  = 1'b1;
        nextCycle();
        TxDone = 1'b0;
        #1;
        vecs++; if (bBusy !== 1'b0) begin errs++; $display("FAIL gap0_stray_idle: got busy %b want 0", bBusy); end
        ReqValid = 4'b0001;
        #1;
        vecs++; if (bReqReady !== 4'b0001) begin errs++; $display("FAIL gap0_ready0: got %b want 0001", bReqReady); end
        nextCycle();
        ReqValid = 4'b0010;
        TxDone   = 1'b1;
        #1;
        vecs++; if (bTxStart !== 1'b1) begin errs++; $display("FAIL gap0_txstart0: got %b want 1", bTxStart); end
        vecs++; if (bReqReady !== 4'b0000) begin errs++; $display("FAIL gap0_ready_start: got %b want 0000", bReqReady); end
        nextCycle();
        TxDone = 1'b0;
        #1;
        vecs++; if (bBusy !== 1'b1) begin errs++; $display("FAIL gap0_stray_start: got busy %b want 1", bBusy); end
        nextCycle();
        nextCycle();
        TxDone = 1'b1;
        nextCycle();
        TxDone = 1'b0;
        #1;
        vecs++; if (bBusy !== 1'b0) begin errs++; $display("FAIL gap0_idle: got busy %b want 0", bBusy); end
        vecs++; if (bTxStart !== 1'b0) begin errs++; $display("FAIL gap0_no_early_start: got %b want 0", bTxStart); end
        vecs++; if (bReqReady !== 4'b0010) begin errs++; $display("FAIL gap0_ready1: got %b want 0010", bReqReady); end
        nextCycle();
        ReqValid = 4'b0000;
        #1;
        vecs++; if (bTxStart !== 1'b1) begin errs++; $display("FAIL gap0_txstart1: got %b want 1", bTxStart); end
        vecs++; if (bTxData !== 8'h66) begin errs++; $display("FAIL gap0_txdata1: got %h want 66", bTxData); end
    endtask

    task automatic test_reset_mid();
        doReset();
        ReqData  = 32'h4433_7711;
        ReqValid = 4'b0100;
        nextCycle();
        ReqValid = 4'b0000;
        repeat (4) nextCycle();
        #1;
        vecs++; if (aTxData !== 8'h33) begin errs++; $display("FAIL rmid_pre_data: got %h want 33", aTxData); end
        ResetN = 1'b0;
        nextCycle();
        ResetN = 1'b1;
        #1;
        vecs++; if (aBusy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", aBusy); end
        vecs++; if (aTxData !== 8'h00) begin errs++; $display("FAIL rmid_txdata: got %h want 00", aTxData); end
        vecs++; if (aGrantId !== 2'd0) begin errs++; $display("FAIL rmid_grantid: got %0d want 0", aGrantId); end
        ReqValid = 4'b1111;
        #1;
        vecs++; if (aReqReady !== 4'b0001) begin errs++; $display("FAIL rmid_ptr0: got %b want 0001", aReqReady); end
        nextCycle();
        ReqValid = 4'b0000;
        #1;
        vecs++; if (aTxData !== 8'h11) begin errs++; $display("FAIL rmid_data0: got %h want 11", aTxData); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_gap0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NUM_REQ byte producers (command responder, status reporter, debug echo, ...) using round-robin arbitration. Captures the winning byte and pulses the transmitter's start strobe. Waits for the transmitter's done strobe, then enforces an inter-frame gap counted in baud-rate-generator ticks. A watchdog aborts a frame whose done strobe never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, byte width per requester
GAP_TICKS, 16, Tick pulses of idle line enforced after each frame (0 = no gap)
TIMEOUT_CYCLES, 200000, Clock cycles allowed in WAIT_DONE before abort (>=2)

Ports:
Clock  input  1  system clock (50 MHz)
ResetN  input  1  synchronous, active-low reset
Tick  input  1  baud oversample tick from the baud rate generator, 1-cycle pulses
ReqValid  input  NUM_REQ  per-requester byte-available flag; held until accepted
ReqData  input  NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS]
ReqReady  output  NUM_REQ  one-hot accept pulse; byte i is consumed when ReqValid[i] and ReqReady[i] are both high
TxStart  output  1  one-cycle start strobe to the transmitter
TxData  output  DATA_BITS  byte to transmit; stable from the TxStart cycle until FSM leaves WAIT_DONE
TxDone  input  1  one-cycle frame-complete strobe from the transmitter
Busy  output  1  high in every state except IDLE
GrantId  output  $clog2(NUM_REQ)  index of the last accepted requester
TimeoutErr  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values: all registered state and outputs are 0. This covers FSM=IDLE, TxStart, TxData, GrantId, TimeoutErr, the pointer and both counters. ReqReady is 0 because the FSM is in IDLE with no pick yet.
- Reset mid-frame returns the FSM to IDLE and drops the captured byte; the transmitter is not told.
- Round-robin pointer Ptr holds the highest-priority index. Search order is Ptr, Ptr+1, ..., wrapping mod NUM_REQ. After each accept, Ptr = winner+1, wrapping mod NUM_REQ.
- FSM states are IDLE, START, WAIT_DONE and GAP.
- IDLE:
  - If any ReqValid bit is high, ReqReady[winner] is asserted combinationally for that cycle.
  - On that clock edge: TxData <= byte, GrantId <= winner, Ptr updates, then go to START.
  - If no ReqValid bit is high, ReqReady is 0.
  - Acceptance latency is 0 cycles from a valid in IDLE.
- START: TxStart = 1 for exactly this one cycle. Watchdog counter clears. Next state is WAIT_DONE.
- WAIT_DONE:
  - If TxDone is high, go to GAP (or to IDLE if GAP_TICKS==0).
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1, TimeoutErr pulses and the FSM goes to GAP (or IDLE).
  - If TxDone and expiry occur in the same cycle, TxDone wins and there is no error.
- TxDone is ignored outside WAIT_DONE.
- GAP:
  - The gap counter counts Tick pulses. On the Tick that makes the count equal GAP_TICKS, go to IDLE.
  - Clock cycles without a Tick do not advance the count.
  - The counter clears on GAP entry.
- ReqReady stays 0 in every state except IDLE. ReqValid changes outside IDLE are ignored.
- Minimum time between TxStart pulses is 3 cycles plus the gap (when the done strobe is immediate).
- Counter widths are $clog2(TIMEOUT_CYCLES) and $clog2(GAP_TICKS+1). Neither counter wraps: each saturates at the compare point and forces the state exit.

Decomposition:
- Package uart_pkg holds:
  - the typedef enum logic [1:0] for the arbiter states {IDLE, START, WAIT_DONE, GAP};
  - localparam DATA_BITS_DEFAULT = 8;
  - a function returning the next index mod n for the pointer wrap.
- Sub-module uart_rr_pick is purely combinational. Inputs are ReqValid and Ptr; outputs are the one-hot Grant, the encoded index and AnyValid. It is instantiated once.
- The FSM, counters and capture registers stay in uart_tx_arbiter.

Test Plan:
- Single requester: ReqValid=0001, ReqData[7:0]=0x55 in IDLE.
  - Response: ReqReady=0001 the same cycle; TxStart one cycle later with TxData=0x55, GrantId=0.
  - TxDone 10 cycles later, then 16 Ticks, then Busy=0.
- Fairness: all four valid continuously, bytes 0xA0..0xA3, TxDone returned after 5 cycles.
  - Required order: 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, each exactly once per rotation.
- Wrap: Ptr=3 (after a grant to requester 2) and ReqValid=0101 -> grant goes to 0, then to 2, and Ptr wraps to 1 after the grant to 0.
- Timeout: TIMEOUT_CYCLES=20, TxDone never returned.
  - Response: TimeoutErr is a single pulse 20 cycles after TxStart; the FSM enters GAP and the next requester is served.
  - Tie case: TxDone in the expiry cycle -> no TimeoutErr.
- GAP_TICKS=0 and a stray TxDone in IDLE/START: after done, the next TxStart occurs 2 cycles later, and the stray TxDone has no effect.
- Reset mid WAIT_DONE (ResetN low for 1 cycle) -> next cycle Busy=0, TxData=0, Ptr=0, and requester 0 wins the next arbitration.
